multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Iterative signed multiply/divide engine and its sequencer, driven by the main control FSM through single-cycle mult_start/div_start pulses.
- Owns the 32-cycle shift-add (Booth radix-2) multiply and 32-cycle restoring divide, and holds results for the HI/LO register writes.
- Reports busy/done so the control FSM waits in its MULT/DIV states.
- Raises divzero for the exception path.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
mult_start  input  1  one-cycle pulse; start signed multiply of a_in*b_in
div_start  input  1  one-cycle pulse; start signed divide a_in/b_in
a_in  input  WIDTH  operand A (multiplicand / dividend)
b_in  input  WIDTH  operand B (multiplier / divisor)
busy  output  1  high while an operation is in progress (not IDLE)
done  output  1  one-cycle pulse: result valid on hi_out/lo_out
divzero  output  1  one-cycle pulse with done when divisor was zero
hi_out  output  WIDTH  product[63:32] or remainder
lo_out  output  WIDTH  product[31:0] or quotient

Behaviour:
- Reset (clk edge with reset=1): state IDLE, iteration counter 0, busy=0, done=0, divzero=0, hi_out=0, lo_out=0, internal operand/accumulator regs 0. Reset overrides any in-flight operation; the result is discarded and no done is produced.
- States: IDLE, MULT, DIV, FIXUP, DONE.
- IDLE:
  - mult_start=1 sampled at edge k: latch a_in/b_in, go MULT, counter=0.
  - Else div_start=1 at edge k:
    - If b_in==0: go DONE with divzero flagged; hi_out/lo_out unchanged.
    - Otherwise: latch |a_in|, |b_in| and both signs, go DIV.
  - Both starts high: multiply wins, div_start is ignored.
- Starts arriving in any state other than IDLE are ignored (no queueing).
- MULT:
  - One Booth step per clock: {acc,Q,q-1}, arithmetic shift right.
  - Counter increments; after WIDTH steps go DONE with hi_out=acc and lo_out=Q.
  - Result is the exact 64-bit two's-complement product.
- DIV:
  - One restoring step per clock on magnitudes: shift {R,Q} left, trial-subtract divisor, set the Q lsb.
  - After WIDTH steps go FIXUP.
- FIXUP (1 cycle):
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - lo_out=quotient, hi_out=remainder. Go DONE.
- DONE (1 cycle): done=1, divzero=1 only for the zero-divisor case. Next state IDLE.
- hi_out/lo_out hold their values until the next completed operation.
- Latency, with start sampled at edge k, done high in the cycle after edge:
  - multiply: k+WIDTH+1
  - divide: k+WIDTH+2
  - divide by zero: k+1
- busy=1 from edge k through the DONE cycle inclusive. busy=0 in IDLE.
- A new start may be sampled on the first edge after DONE (back-to-back allowed).
- Overflow case: -2^(WIDTH-1) / -1 gives lo_out=0x80000000 (wraps), hi_out=0. No flag is raised; overflow detection belongs to the control unit.
- Operand changes after edge k do not affect the result.
- Outputs are registered. done and divzero are registered, decoded from DONE.

Test Plan:
- Multiply 7 * -3 (0x00000007, 0xFFFFFFFD). Required: done exactly 33 cycles after the start edge, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, busy high for cycles 1..33.
- Multiply 0x80000000 * 0x80000000. Required: hi_out=0x40000000, lo_out=0x00000000.
- Divide -7 / 2 (0xFFFFFFF9, 0x00000002). Required: done after 34 cycles, lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
- Divide 100 by 0 with previous hi_out/lo_out = 0x12/0x34. Required: done=divzero=1 one cycle after the start edge, hi_out/lo_out stay 0x12/0x34, then the block returns to IDLE.
- Robustness sequence:
  - Assert div_start at cycle 10 of a running multiply: ignored, and the multiply result is correct.
  - Assert mult_start and div_start together: a multiply is performed.
  - Issue back-to-back operations: the second start, on the edge after done, is accepted.
- Assert reset at cycle 15 of a divide. Required: next cycle busy=0, hi_out=lo_out=0, no done pulse; a following multiply 5*5 gives lo_out=25 and hi_out=0.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide engine: 32-step Booth radix-2 multiply and
// 32-step restoring divide with sign fix-up, holding results for HI/LO writes.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_DIV   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [WIDTH-1:0] m_q;
    logic             sign_a_q, sign_b_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             last_step;
    logic             accept;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic             booth_q1;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   div_r;
    logic [WIDTH-1:0] div_q;

    assign last_step = (cnt_q == CW'(WIDTH - 1));
    // DONE accepts a start on its exiting edge so operations can run back-to-back.
    assign accept    = (state_q == S_IDLE) || (state_q == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (mult_start) begin
                    state_d = S_MULT;
                end else if (div_start) begin
                    state_d = (b_in == '0) ? S_DONE : S_DIV;
                end
            end
            S_MULT:  if (last_step) state_d = S_DONE;
            S_DIV:   if (last_step) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        divzero = (state_q == S_DONE) && dz_q;
        hi_out  = hi_q;
        lo_out  = lo_q;
    end

    // Booth step on {acc,Q,q-1}; acc carries one guard bit so -2^(W-1) multiplicands add safely.
    always_comb begin
        m_ext     = {m_q[WIDTH-1], m_q};
        booth_sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
        booth_q1  = q_q[0];
    end

    // Restoring divide step on magnitudes; trial msb is the borrow.
    always_comb begin
        r_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = r_shift - {1'b0, m_q};
        if (!trial[WIDTH]) begin
            div_r = trial;
            div_q = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            div_r = r_shift;
            div_q = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_MULT: begin
                    acc_q <= booth_acc;
                    q_q   <= booth_q;
                    q1_q  <= booth_q1;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        hi_q <= booth_acc[WIDTH-1:0];
                        lo_q <= booth_q;
                    end
                end
                S_DIV: begin
                    acc_q <= div_r;
                    q_q   <= div_q;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIXUP: begin
                    lo_q <= (sign_a_q ^ sign_b_q) ? -q_q : q_q;
                    hi_q <= sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                default: begin
                    if (accept && mult_start) begin
                        acc_q <= '0;
                        q_q   <= b_in;
                        q1_q  <= 1'b0;
                        m_q   <= a_in;
                        cnt_q <= '0;
                        dz_q  <= 1'b0;
                    end else if (accept && div_start) begin
                        dz_q <= (b_in == '0);
                        if (b_in != '0) begin
                            acc_q    <= '0;
                            q_q      <= a_in[WIDTH-1] ? -a_in : a_in;
                            m_q      <= b_in[WIDTH-1] ? -b_in : b_in;
                            sign_a_q <= a_in[WIDTH-1];
                            sign_b_q <= b_in[WIDTH-1];
                            cnt_q    <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed corner cases plus random
// operations compared against plain 64-bit arithmetic.
module tb_multdiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] a_in, b_in;
    logic        busy, done, divzero;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .mult_start(mult_start), .div_start(div_start),
        .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .divzero(divzero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        if ($urandom_range(1) == 0) return 32'($urandom_range(1000));
        return $urandom;
    endfunction

    // Called at a negedge; returns at the negedge where done was observed.
    task automatic do_op(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
        int     cyc;
        int     exp_lat;
        bit     exp_dz;
        bit     busy_ok;
        longint sa, sb, prod, quo, rem;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        if (ms) begin
            prod = sa * sb;
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
            exp_lat = 33;
        end else if (b == 32'd0) begin
            exp_dz = 1'b1;
            exp_lat = 1;
        end else begin
            quo = sa / sb;
            rem = sa % sb;
            exp_hi = rem[31:0];
            exp_lo = quo[31:0];
            exp_lat = 34;
        end
        mult_start = ms; div_start = ds; a_in = a; b_in = b;
        @(negedge clk);
        a_in = $urandom; b_in = $urandom;
        cyc = 1; busy_ok = 1'b1;
        while (1) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) break;
            if (cyc >= 100) break;
            if (inj != 0 && cyc == inj) begin
                mult_start = 1'b1; div_start = 1'b1;
            end else begin
                mult_start = 1'b0; div_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        mult_start = 1'b0; div_start = 1'b0;
        $display("op %s a=%h b=%h inj=%0d -> hi=%h lo=%h divzero=%b latency=%0d",
                 ms ? "mul" : "div", a, b, inj, hi_out, lo_out, divzero, cyc);
        check_value("latency", 64'(cyc), 64'(exp_lat));
        check_value("busy_during_op", 64'(busy_ok), 64'd1);
        check_value("hi_out", 64'(hi_out), 64'(exp_hi));
        check_value("lo_out", 64'(lo_out), 64'(exp_lo));
        check_value("divzero", 64'(divzero), 64'(exp_dz));
    endtask

    task automatic idle_check();
        @(negedge clk);
        check_value("idle_busy", 64'(busy), 64'd0);
        check_value("idle_done", 64'(done), 64'd0);
    endtask

    initial begin
        bit no_done;
        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0;
        a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check_value("reset_busy", 64'(busy), 64'd0);
        check_value("reset_done", 64'(done), 64'd0);
        check_value("reset_divzero", 64'(divzero), 64'd0);
        check_value("reset_hi", 64'(hi_out), 64'd0);
        check_value("reset_lo", 64'(lo_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        idle_check();
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        idle_check();
        do_op(0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        idle_check();
        do_op(0, 1, 32'h0000_0692, 32'h0000_0020, 0);
        do_op(0, 1, 32'd100, 32'd0, 0);
        idle_check();
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        // Starts injected mid-operation are ignored
        do_op(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        do_op(0, 1, 32'h8765_4321, 32'h0000_0013, 20);
        // Simultaneous starts: multiply wins
        do_op(1, 1, 32'hFFFF_FF00, 32'h0000_0010, 0);
        idle_check();

        // Reset in the middle of a divide
        div_start = 1'b1; a_in = 32'd1000; b_in = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check_value("rst_mid_busy", 64'(busy), 64'd0);
        check_value("rst_mid_done", 64'(done), 64'd0);
        check_value("rst_mid_hi", 64'(hi_out), 64'd0);
        check_value("rst_mid_lo", 64'(lo_out), 64'd0);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) no_done = 1'b0;
        end
        check_value("rst_no_done", 64'(no_done), 64'd1);
        do_op(1, 0, 32'd5, 32'd5, 0);

        // Random back-to-back operations
        for (int i = 0; i < 40; i++) begin
            bit          is_mult;
            logic [31:0] ra, rb;
            is_mult = ($urandom_range(1) == 1);
            ra = pick_operand();
            rb = pick_operand();
            if ($urandom_range(7) == 0) rb = 32'd0;
            do_op(is_mult, !is_mult, ra, rb, ($urandom_range(3) == 0) ? int'($urandom_range(1, 25)) : 0);
            if ($urandom_range(2) == 0) idle_check();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
